vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the 640x480 VGA display path. Runs on the pixel clock and produces the `DrawX`/`DrawY` pixel coordinates, the active-video `blank` flag, and the sync outputs consumed by the sprite/background draw stages. The draw stages register RGB one cycle after the coordinates, so sync is delayed one extra cycle here to stay aligned with the colour data at the pins. It also supplies a frame-start pulse and a frame counter for animation logic.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line
- `H_FP`, default 16: horizontal front porch, in pixels
- `H_SYNC`, default 96: hsync width, in pixels
- `H_BP`, default 48: horizontal back porch, in pixels
- `V_ACTIVE`, default 480: visible lines per frame
- `V_FP`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vsync width, in lines
- `V_BP`, default 33: vertical back porch, in lines
- Derived values: `H_TOTAL` = sum of all H params (800); `V_TOTAL` = sum of all V params (525). Both must be ≤ 1024.
- `vga_clk`  in  1: pixel clock (25 MHz). Single clock domain; everything updates on the rising edge.
- `reset_n`  in  1: synchronous reset, active low.
- `DrawX`  out  10: current pixel column, range 0..H_TOTAL-1.
- `DrawY`  out  10: current pixel line, range 0..V_TOTAL-1.
- `blank`  out  1: 1 = active video (DrawX < H_ACTIVE and DrawY < V_ACTIVE); 0 = blanking.
- `hs`  out  1: horizontal sync, active low, delayed one cycle relative to `DrawX`.
- `vs`  out  1: vertical sync, active low, delayed one cycle relative to `DrawX`/`DrawY`.
- `frame_start`  out  1: one-cycle pulse while `DrawX`=0 and `DrawY`=0.
- `frame_count`  out  8: count of completed frames; wraps modulo 256.

## Operation
- Counters
  - `DrawX` and `DrawY` are the counter registers themselves.
  - `DrawX` increments each cycle. At H_TOTAL-1 it wraps to 0.
  - `DrawY` increments only on the cycle where `DrawX` wraps. At V_TOTAL-1 it wraps to 0.
- `blank` is a register. It is loaded from the *next* counter values, so it is always consistent with the `DrawX`/`DrawY` presented in the same cycle.
- Sync generation
  - Internal hsync is low for `DrawX` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - Internal vsync is low for `DrawY` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - `hs` and `vs` are these internal values registered once more (+1 cycle).
- Frame tracking
  - `frame_start` is a register, loaded when the next counter state is (0,0).
  - `frame_count` increments on the same edge that raises `frame_start`. 255 wraps to 0.
- Reset (`reset_n`=0 at a rising edge) forces:
  - `DrawX`=0, `DrawY`=0
  - `blank`=0
  - `hs`=1, `vs`=1
  - `frame_start`=0
  - `frame_count`=0
  - Internal sync pipeline bits = 1.
- Reset mid-frame aborts the frame immediately, with no partial sync pulse left in the pipeline. `frame_count` is not incremented for the aborted frame.

## Timing
- After the first rising edge with `reset_n`=1, `DrawX`=1, `DrawY`=0, `blank`=1.
  - Pixel (0,0) of the very first frame is shown with `blank`=0. This is intentional.
- After N edges with `reset_n`=1: `DrawX` = N mod 800, `DrawY` = (N div 800) mod 525.
- Line period is 800 cycles; frame period is 420000 cycles.
- The first `frame_start` pulse comes 420000 edges after reset release. `frame_count` becomes 1 on that same edge.
- `blank`: high for `DrawX` 0..639 on lines 0..479; low elsewhere, including all of lines 480..524.
- `hs` is low in cycles where `DrawX` ∈ 657..752 (96 cycles). It is high at `DrawX`=656 and `DrawX`=753.
- `vs` falls on the cycle with `DrawY`=490, `DrawX`=1. It rises on the cycle with `DrawY`=492, `DrawX`=1. Low duration is exactly 1600 cycles.
- `hs` keeps toggling during vertical blanking and during `vs` low.
- `frame_start` and `frame_count` are ignored by sync generation; they impose no stall.
- There are no handshakes: the block free-runs and never waits on downstream.

## Test plan
- Reset then release: during reset all outputs equal their reset values. On the first edge after release: `DrawX`=1, `DrawY`=0, `blank`=1, `hs`=1, `vs`=1.
- Line wrap: with `DrawX`=799, `DrawY`=10, the next cycle gives `DrawX`=0, `DrawY`=11. `blank` goes 0→1 at that transition.
- Horizontal sync: over line 5, count exactly 96 cycles of `hs`=0, spanning `DrawX` 657..752. Over the same line, `blank`=1 for exactly 640 cycles.
- Vertical sync and frame wrap: `vs`=0 for exactly 1600 cycles, starting at (`DrawX`,`DrawY`)=(1,490). At (799,524)→(0,0), `frame_start`=1 for one cycle and `frame_count` increments.
- Frame counter wrap: run 256 frames. `frame_count` goes 255→0 on the 256th `frame_start`, with exactly 420000 cycles between pulses.
- Reset mid-operation: assert `reset_n`=0 at `DrawX`=700, `DrawY`=491, while `hs`=0 and `vs`=0. On the next edge all outputs return to reset values (`hs`=1, `vs`=1, `frame_count`=0). After release, counting restarts per the first scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, active-video flag, delayed syncs,
// and frame-start pulse with a modulo-256 frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       blank_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       fstart_nxt;
  logic       hsync_p0;
  logic       vsync_p0;

  always_comb begin
    x_nxt = DrawX + 10'd1;
    y_nxt = DrawY;
    if (DrawX == X_LAST) begin
      x_nxt = 10'd0;
      y_nxt = (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
    end
  end

  // Flags are derived from the next counter state so they register in step with it
  always_comb begin
    blank_nxt  = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    hsync_nxt  = !((x_nxt >= HS_LO) && (x_nxt <= HS_HI));
    vsync_nxt  = !((y_nxt >= VS_LO) && (y_nxt <= VS_HI));
    fstart_nxt = (x_nxt == 10'd0) && (y_nxt == 10'd0);
  end

  // Stage p0: counters, blank, internal syncs, frame tracking
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      blank       <= 1'b0;
      hsync_p0    <= 1'b1;
      vsync_p0    <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank       <= blank_nxt;
      hsync_p0    <= hsync_nxt;
      vsync_p0    <= vsync_nxt;
      frame_start <= fstart_nxt;
      if (fstart_nxt) frame_count <= frame_count + 8'd1;
    end
  end

  // Stage p1: syncs delayed one more cycle to line up with registered RGB
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hs <= 1'b1;
      vs <= 1'b1;
    end else begin
      hs <= hsync_p0;
      vs <= vsync_p0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster (15x10) so that
// 256 full frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2, HT = 15;
  localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1, VT = 10;
  localparam int FT = 150;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs, vs, frame_start;
  logic [7:0] frame_count;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .hs(hs), .vs(vs), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
    logic       rst;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   n = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected outputs after n clean edges since reset (n==0: reset state)
  function automatic exp_t model(input int k);
    exp_t e;
    int x, y, xp, yp;
    x = k % HT;
    y = (k / HT) % VT;
    e.x = 10'(x);
    e.y = 10'(y);
    e.rst = (k == 0);
    e.blank = (k > 0) && (x < HA) && (y < VA);
    if (k == 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      xp = (k - 1) % HT;
      yp = ((k - 1) / HT) % VT;
      e.hs = !((xp >= HA + HFP) && (xp <= HA + HFP + HSW - 1));
      e.vs = !((yp >= VA + VFP) && (yp <= VA + VFP + VSW - 1));
    end
    e.fs = (k > 0) && (k % FT == 0);
    e.fc = 8'((k / FT) % 256);
    return e;
  endfunction

  task automatic step(input bit r);
    @(negedge vga_clk);
    reset_n = r;
    @(posedge vga_clk);
    if (!r) n = 0;
    else n++;
    q.push_back(model(n));
  endtask

  // Monitor: per-cycle scoreboard compare plus hand-computed run-length checks
  int  cyc = 0, fs_last = -1, wraps = 0;
  int  hs_cnt = 0, vs_cnt = 0;
  bit  hs_ok = 0, vs_ok = 0, prev_hs = 1, prev_vs = 1;
  logic [7:0] prev_fc = 8'd0;

  always @(negedge vga_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [31:0] act, req;
      e = q.pop_front();
      cyc++;
      act = {DrawX, DrawY, blank, hs, vs, frame_start, frame_count};
      req = {e.x, e.y, e.blank, e.hs, e.vs, e.fs, e.fc};
      checks++;
      if (act !== req) begin
        errs++;
        $display("FAIL cycle n=%0d: got x=%0d y=%0d bl=%b hs=%b vs=%b fs=%b fc=%0d expected x=%0d y=%0d bl=%b hs=%b vs=%b fs=%b fc=%0d",
                 n, DrawX, DrawY, blank, hs, vs, frame_start, frame_count,
                 e.x, e.y, e.blank, e.hs, e.vs, e.fs, e.fc);
      end
      if (e.rst) begin
        hs_ok = 0; vs_ok = 0; hs_cnt = 0; vs_cnt = 0; fs_last = -1;
      end else begin
        if (!hs) begin
          if (prev_hs) begin
            hs_ok = 1; hs_cnt = 0;
            chk("hs_fall_x", int'(DrawX), 11);       // 8+2+1
          end
          hs_cnt++;
        end else if (!prev_hs && hs_ok) begin
          chk("hs_width", hs_cnt, 3);
          hs_ok = 0;
        end
        if (!vs) begin
          if (prev_vs) begin
            vs_ok = 1; vs_cnt = 0;
            chk("vs_fall_xy", int'({DrawY, DrawX}), int'({10'd7, 10'd1}));
          end
          vs_cnt++;
        end else if (!prev_vs && vs_ok) begin
          chk("vs_width", vs_cnt, 30);                // 2 lines x 15
          vs_ok = 0;
        end
        if (frame_start) begin
          if (fs_last >= 0) chk("frame_period", cyc - fs_last, 150);
          chk("fc_step", int'(frame_count), int'(8'(prev_fc + 8'd1)));
          if (frame_count == 8'd0) wraps++;
          fs_last = cyc;
        end
      end
      prev_hs = hs;
      prev_vs = vs;
      prev_fc = frame_count;
    end
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) step(1'b0);
    repeat (256 * FT + 5) step(1'b1);
    // Reset mid-frame while both syncs are low (x=12 on line 8)
    while (!((n % HT == 12) && ((n / HT) % VT == 8))) step(1'b1);
    repeat (2) step(1'b0);
    repeat (40) step(1'b1);
    @(negedge vga_clk);
    @(negedge vga_clk);
    #1;
    chk("fc_wraps", wraps, 1);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
